// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg
// Shared types for the diaosi pipeline control logic.
//   hz_state_t : hazard sequencer state (HZ_RUN, HZ_LUSTALL)
//   hz_bcnt_t  : remaining load-use bubble count
//   HZ_IFID / HZ_IDEX / HZ_EXMEM : indices of the front pipeline registers
package diaosi_types_pkg;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_LUSTALL = 1'b1
  } hz_state_t;

  typedef logic [2:0] hz_bcnt_t;

  localparam int HZ_IFID  = 0;
  localparam int HZ_IDEX  = 1;
  localparam int HZ_EXMEM = 2;

endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter
// Single 32-bit event counter that saturates at all-ones.
// Ports:
//   CLK   in  core clock
//   nRST  in  synchronous active-low reset (clears the count)
//   inc   in  count one event this cycle
//   count out current count value
module hazard_perf_counter (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard / pipeline-control unit: PC enable and per-register latch enable and
// flush vectors from fetch/data completion, EX redirects and load-use hazards.
// Load-use hazards are handled by a registered sequencer that inserts
// LOAD_BUBBLES bubbles, counting only cycles in which the pipe advances.
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   ihit, dhit           fetch / data access complete this cycle
//   dmem_req             EX/MEM has a memory request outstanding
//   redirect             EX resolved a jump / JR / taken branch
//   ex_memrd, ex_wsel    ID/EX is a load, and its destination register
//   id_rs, id_rt         IF/ID source registers; id_uses_rt qualifies rt
//   pc_en                PC update enable
//   stage_en             per-register latch enable (0 = IF/ID)
//   stage_flush          per-register bubble insert (only where enabled)
// Optional build macro HAZARD_PERF_CNT_EN adds the saturating outputs
//   stall_cycles, flush_events, lu_events.
module pipeline_hazard_ctrl
  import diaosi_types_pkg::*;
#(
  parameter int NSTAGE       = 4,
  parameter int REG_W        = 5,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dmem_req,
  input  logic              redirect,
  input  logic              ex_memrd,
  input  logic [REG_W-1:0]  ex_wsel,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  output logic              pc_en,
  output logic [NSTAGE-1:0] stage_en,
  output logic [NSTAGE-1:0] stage_flush
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events,
  output logic [31:0]       lu_events
`endif
);

  hz_state_t state_reg, state_next;
  hz_bcnt_t  bcnt_reg, bcnt_next;

  logic memwait;
  logic advance;
  logic luhaz;
  logic [NSTAGE-1:0] back_mask;

  assign memwait = dmem_req & ~dhit;
  assign advance = ihit & ~memwait;
  assign luhaz   = ex_memrd && (ex_wsel != '0) &&
                   ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));

  // Registers from EX/MEM backwards; these drain on a data hit during a fetch miss.
  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_back
      assign back_mask[gi] = (gi >= HZ_EXMEM);
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg <= HZ_RUN;
      bcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bcnt_next   = bcnt_reg;
    pc_en       = 1'b0;
    stage_en    = '0;
    stage_flush = '0;
    if (!nRST) begin
      // Clear the whole pipe while reset is held.
      stage_en    = '1;
      stage_flush = '1;
      state_next  = HZ_RUN;
      bcnt_next   = '0;
    end else if (memwait) begin
      // Everything holds.
    end else if (!ihit) begin
      if (dmem_req && dhit) begin
        // Capture the completed memory access so it is not reissued.
        stage_en               = back_mask;
        stage_flush[HZ_EXMEM]  = 1'b1;
      end
    end else if (redirect) begin
      pc_en                = 1'b1;
      stage_en             = '1;
      stage_flush[HZ_IFID] = 1'b1;
      stage_flush[HZ_IDEX] = 1'b1;
      state_next           = HZ_RUN;
      bcnt_next            = '0;
    end else if ((state_reg == HZ_LUSTALL) || luhaz) begin
      // Bubble into ID/EX while IF/ID and the PC hold.
      stage_en              = '1;
      stage_en[HZ_IFID]     = 1'b0;
      stage_flush[HZ_IDEX]  = 1'b1;
      if (state_reg == HZ_RUN) begin
        if (LOAD_BUBBLES > 1) begin
          state_next = HZ_LUSTALL;
          bcnt_next  = hz_bcnt_t'(LOAD_BUBBLES - 1);
        end
      end else begin
        bcnt_next = bcnt_reg - 3'd1;
        if (bcnt_reg == 3'd1) begin
          state_next = HZ_RUN;
        end
      end
    end else begin
      pc_en    = 1'b1;
      stage_en = '1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;
  logic lu_inc;

  assign stall_inc = ~pc_en;
  assign flush_inc = advance & redirect;
  assign lu_inc    = advance & ~redirect & (state_reg == HZ_RUN) & luhaz;

  hazard_perf_counter u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  hazard_perf_counter u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_inc),
    .count (flush_events)
  );

  hazard_perf_counter u_lu_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (lu_inc),
    .count (lu_events)
  );
`else
  logic unused_advance;
  assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (LOAD_BUBBLES 1/3/4, NSTAGE
// 4/6/4) share one stimulus stream and are checked against a rule-table model
// that tracks remaining bubbles as a plain integer per instance.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST, ihit, dhit, dmem_req, redirect, ex_memrd, id_uses_rt;
  logic [4:0] ex_wsel, id_rs, id_rt;

  logic       pc1, pc3, pc4;
  logic [3:0] en1, fl1, en4, fl4;
  logic [5:0] en3, fl3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc [3];
  logic [31:0] fe [3];
  logic [31:0] le [3];
`endif

  int vectors = 0;
  int miscompares = 0;

  int rem [3];
  int ns_of [3] = '{4, 6, 4};
  int lb_of [3] = '{1, 3, 4};
  logic [16:0] obs [3];

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.NSTAGE(4), .REG_W(5), .LOAD_BUBBLES(1)) u1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .redirect(redirect), .ex_memrd(ex_memrd), .ex_wsel(ex_wsel), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .pc_en(pc1), .stage_en(en1),
    .stage_flush(fl1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[0]), .flush_events(fe[0]), .lu_events(le[0])
`endif
  );

  pipeline_hazard_ctrl #(.NSTAGE(6), .REG_W(5), .LOAD_BUBBLES(3)) u3 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .redirect(redirect), .ex_memrd(ex_memrd), .ex_wsel(ex_wsel), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .pc_en(pc3), .stage_en(en3),
    .stage_flush(fl3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[1]), .flush_events(fe[1]), .lu_events(le[1])
`endif
  );

  pipeline_hazard_ctrl #(.NSTAGE(4), .REG_W(5), .LOAD_BUBBLES(4)) u4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .redirect(redirect), .ex_memrd(ex_memrd), .ex_wsel(ex_wsel), .id_rs(id_rs),
    .id_rt(id_rt), .id_uses_rt(id_uses_rt), .pc_en(pc4), .stage_en(en4),
    .stage_flush(fl4)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc[2]), .flush_events(fe[2]), .lu_events(le[2])
`endif
  );

  assign obs[0] = {pc1, 4'b0, en1, 4'b0, fl1};
  assign obs[1] = {pc3, 2'b0, en3, 2'b0, fl3};
  assign obs[2] = {pc4, 4'b0, en4, 4'b0, fl4};

  // Rule-table reference: r = bubbles still owed (0 = running normally).
  function automatic void model(input int ns, input int lb, input int r,
                                output logic [16:0] o, output int r_next);
    logic [7:0] all, en, fl;
    logic pc, mw, haz;
    all = 8'((9'd1 << ns) - 9'd1);
    mw  = dmem_req && !dhit;
    haz = ex_memrd && (ex_wsel != 0) &&
          ((ex_wsel == id_rs) || (id_uses_rt && ex_wsel == id_rt));
    r_next = r; pc = 1'b0; en = 8'h00; fl = 8'h00;
    if (!nRST) begin
      en = all; fl = all; r_next = 0;
    end else if (mw) begin
      r_next = r;
    end else if (!ihit) begin
      if (dmem_req && dhit) begin en = all & 8'hFC; fl = 8'h04; end
    end else if (redirect) begin
      pc = 1'b1; en = all; fl = 8'h03; r_next = 0;
    end else if (r > 0) begin
      en = all & 8'hFE; fl = 8'h02; r_next = r - 1;
    end else if (haz) begin
      en = all & 8'hFE; fl = 8'h02; r_next = lb - 1;
    end else begin
      pc = 1'b1; en = all;
    end
    o = {pc, en, fl};
  endfunction

  always @(posedge CLK) begin
    logic [16:0] o;
    int rn;
    for (int k = 0; k < 3; k++) begin
      model(ns_of[k], lb_of[k], rem[k], o, rn);
      rem[k] <= rn;
    end
  end

  task automatic set_idle();
    nRST = 1'b1; ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; redirect = 1'b0;
    ex_memrd = 1'b0; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
  endtask

  task automatic set_hazard();
    ex_memrd = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8; id_rt = 5'd3; id_uses_rt = 1'b0;
  endtask

  task automatic drain();
    logic [16:0] e;
    int rn;
    set_idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        model(ns_of[k], lb_of[k], rem[k], e, rn);
        vectors++;
        if (obs[k] !== e) begin
          miscompares++;
          $display("FAIL drain inst%0d: got %h expected %h", k, obs[k], e);
        end
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    logic [16:0] e;
    int rn;
    set_idle();
    nRST = 1'b0; dmem_req = 1'b1; redirect = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        model(ns_of[k], lb_of[k], rem[k], e, rn);
        vectors++;
        if (obs[k] !== e) begin
          miscompares++;
          $display("FAIL reset inst%0d: got %h expected %h", k, obs[k], e);
        end
      end
      vectors++;
      if ({pc1, en1, fl1} !== 9'b0_1111_1111) begin
        miscompares++;
        $display("FAIL reset_const: got %b expected 011111111", {pc1, en1, fl1});
      end
      @(posedge CLK); #1;
    end
    set_idle();
  endtask

  task automatic test_load_use();
    logic [16:0] e;
    int rn;
    set_idle();
    set_hazard();
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      model(ns_of[k], lb_of[k], rem[k], e, rn);
      vectors++;
      if (obs[k] !== e) begin
        miscompares++;
        $display("FAIL load_use inst%0d: got %h expected %h", k, obs[k], e);
      end
    end
    vectors++;
    if ({pc1, en1, fl1} !== 9'b0_1110_0010) begin
      miscompares++;
      $display("FAIL load_use_const: got %b expected 011100010", {pc1, en1, fl1});
    end
    @(posedge CLK); #1;
    set_idle();
    @(negedge CLK);
    vectors++;
    if ({pc1, en1, fl1} !== 9'b1_1111_0000) begin
      miscompares++;
      $display("FAIL load_use_after: got %b expected 111110000", {pc1, en1, fl1});
    end
    @(posedge CLK); #1;
    drain();
  endtask

  task automatic test_reg0();
    set_idle();
    ex_memrd = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pc1, en1, fl1, pc3, en3} !== {9'b1_1111_0000, 7'b1_111111}) begin
      miscompares++;
      $display("FAIL reg0: got %b expected 1111100001111111", {pc1, en1, fl1, pc3, en3});
    end
    @(posedge CLK); #1;
    drain();
  endtask

  task automatic test_fetch_miss_stall();
    logic [16:0] e;
    int rn, bubbles;
    bubbles = 0;
    for (int c = 0; c < 8; c++) begin
      set_idle();
      if (c == 0) set_hazard();
      if (c == 1 || c == 2) ihit = 1'b0;
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        model(ns_of[k], lb_of[k], rem[k], e, rn);
        vectors++;
        if (obs[k] !== e) begin
          miscompares++;
          $display("FAIL fetch_miss c%0d inst%0d: got %h expected %h", c, k, obs[k], e);
        end
      end
      if (ihit && !pc3 && fl3[1] && en3[1]) bubbles++;
      if (!ihit) begin
        vectors++;
        if ({pc3, en3, fl3} !== 13'd0) begin
          miscompares++;
          $display("FAIL fetch_miss_hold c%0d: got %b expected 0", c, {pc3, en3, fl3});
        end
      end
      @(posedge CLK); #1;
    end
    vectors++;
    if (bubbles !== 3) begin
      miscompares++;
      $display("FAIL fetch_miss_bubbles: got %0d expected 3", bubbles);
    end
    drain();
  endtask

  task automatic test_redirect_hazard();
    set_idle();
    set_hazard();
    redirect = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pc1, en1, fl1, pc4, fl4} !== {9'b1_1111_0011, 5'b1_0011}) begin
      miscompares++;
      $display("FAIL redirect_haz: got %b expected 11111001110011", {pc1, en1, fl1, pc4, fl4});
    end
    @(posedge CLK); #1;
    set_idle();
    @(negedge CLK);
    vectors++;
    if ({pc4, en4, fl4, pc3, en3} !== {9'b1_1111_0000, 7'b1_111111}) begin
      miscompares++;
      $display("FAIL redirect_state: got %b expected 1111100001111111", {pc4, en4, fl4, pc3, en3});
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_data_hit();
    set_idle();
    ihit = 1'b0; dmem_req = 1'b1; dhit = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({pc1, en1, fl1, en3, fl3} !== {9'b0_1100_0100, 12'b111100_000100}) begin
      miscompares++;
      $display("FAIL data_hit: got %b expected 011000100111100000100", {pc1, en1, fl1, en3, fl3});
    end
    @(posedge CLK); #1;
    dhit = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({pc1, en1, fl1} !== 9'd0) begin
      miscompares++;
      $display("FAIL memwait: got %b expected 000000000", {pc1, en1, fl1});
    end
    @(posedge CLK); #1;
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_idle();
    set_hazard();
    @(posedge CLK); #1;
    set_idle();
    nRST = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({pc4, en4, fl4} !== 9'b0_1111_1111) begin
      miscompares++;
      $display("FAIL reset_mid: got %b expected 011111111", {pc4, en4, fl4});
    end
    @(posedge CLK); #1;
    set_idle();
    @(negedge CLK);
    vectors++;
    if ({pc4, en4, fl4} !== 9'b1_1111_0000) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected 111110000", {pc4, en4, fl4});
    end
`ifdef HAZARD_PERF_CNT_EN
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({sc[k], fe[k], le[k]} !== 96'd0) begin
        miscompares++;
        $display("FAIL perf_reset inst%0d: got %h %h %h expected 0", k, sc[k], fe[k], le[k]);
      end
    end
`endif
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    logic [16:0] e;
    int rn;
    for (int c = 0; c < 400; c++) begin
      nRST       = ($urandom_range(0, 49) != 0);
      ihit       = ($urandom_range(0, 4) != 0);
      dmem_req   = ($urandom_range(0, 9) < 3);
      dhit       = $urandom_range(0, 1) != 0;
      redirect   = ($urandom_range(0, 9) == 0);
      ex_memrd   = ($urandom_range(0, 9) < 4);
      ex_wsel    = 5'($urandom_range(0, 3));
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_uses_rt = $urandom_range(0, 1) != 0;
      @(negedge CLK);
      for (int k = 0; k < 3; k++) begin
        model(ns_of[k], lb_of[k], rem[k], e, rn);
        vectors++;
        if (obs[k] !== e) begin
          miscompares++;
          $display("FAIL random c%0d inst%0d: got %h expected %h", c, k, obs[k], e);
        end
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) rem[k] = 0;
    set_idle();
    nRST = 1'b0;
    @(posedge CLK); #1;
    test_reset();
    test_load_use();
    test_reg0();
    test_fetch_miss_stall();
    test_redirect_hazard();
    test_data_hit();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard and pipeline-control unit for the diaosi pipelined core. It generates the PC enable and per-stage latch enable/flush vectors from ihit, dhit, branch/jump redirect and load-use detection. Unlike the single-bubble combinational predecessor, it has a registered load-use stall sequencer with configurable bubble depth. It also ignores hazards on register 0, gives a defined priority to simultaneous events, and has an optional performance-counter block. It sits between the decode/execute datapath and every pipeline register.

## Interface
Parameters:
- NSTAGE, 4: number of pipeline registers; index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3..NSTAGE-1 = back stages; legal range 4..8
- REG_W, 5: register-select width
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard; legal range 1..7

Ports:
- CLK  in  1  core clock; all state updates on rising edge
- nRST  in  1  reset, synchronous and active-low
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- dmem_req  in  1  EX/MEM holds a load or store with a request outstanding
- redirect  in  1  EX resolved a jump, JR or taken branch
- ex_memrd  in  1  ID/EX instruction is LW or LL
- ex_wsel  in  REG_W  destination register of the ID/EX instruction
- id_rs, id_rt  in  REG_W  source registers of the IF/ID instruction
- id_uses_rt  in  1  IF/ID instruction reads rt
- pc_en  out  1  PC update enable
- stage_en  out  NSTAGE  per-register latch enable
- stage_flush  out  NSTAGE  per-register bubble insert; applies only where stage_en is 1

## Operation
- Definitions:
  - memwait = dmem_req & !dhit
  - advance = ihit & !memwait
  - luhaz = ex_memrd & (ex_wsel != 0) & ((ex_wsel == id_rs) | (id_uses_rt & ex_wsel == id_rt))
- States are HZ_RUN and HZ_LUSTALL. A bubble counter bcnt (3 bits) is valid in HZ_LUSTALL.
- HZ_RUN, decided in priority order:
  1. memwait: pc_en=0, all stage_en=0, all flush=0.
  2. !ihit with dmem_req & dhit: stage_en[2..NSTAGE-1]=1, stage_flush[2]=1. Stages 0–1 and the PC hold. The memory result is captured and the request is not reissued.
  3. !ihit otherwise: everything holds.
  4. redirect: all enables=1, pc_en=1, stage_flush[0]=stage_flush[1]=1.
  5. luhaz: pc_en=0, stage_en[0]=0, stage_en[1]=1 with flush[1]=1, stage_en[2..]=1. If LOAD_BUBBLES>1, go to HZ_LUSTALL with bcnt=LOAD_BUBBLES-1.
  6. Otherwise: everything enabled, no flush.
- HZ_LUSTALL:
  - memwait, or any !ihit case, behaves as in HZ_RUN items 1–3. State and bcnt hold.
  - redirect with advance: same as item 4, and return to HZ_RUN.
  - advance otherwise: same outputs as item 5. bcnt decrements; when bcnt==1 the next state is HZ_RUN.
- Counter arithmetic is unsigned. bcnt never wraps below 1 while in HZ_LUSTALL.

## Timing
- Outputs are combinational from the current state and inputs; state and bcnt are registered. Latency from a hazard to its bubble is 0 cycles.
- A load-use hazard costs exactly LOAD_BUBBLES advancing cycles. Non-advancing cycles do not count.
- Reset (nRST low at an edge): next state HZ_RUN, bcnt=0, counters=0.
- While nRST is low, outputs are pc_en=0, stage_en all 1 and stage_flush all 1, so the pipe clears synchronously.
- Reset asserted mid-stall abandons the stall; the first cycle after release is HZ_RUN.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_cycles (32 bits), flush_events (32 bits) and lu_events (32 bits).
  - stall_cycles increments every cycle pc_en=0 outside reset.
  - flush_events increments on each applied redirect flush.
  - lu_events increments on each HZ_RUN luhaz entry.
  - All three saturate at all-ones.
- HAZARD_PERF_CNT_EN undefined: these ports and their logic are absent, and the remaining behaviour is identical.

## Structure
- diaosi_types_pkg gains:
  - enum hz_state_t {HZ_RUN, HZ_LUSTALL}
  - constants HZ_IFID=0, HZ_IDEX=1, HZ_EXMEM=2
  - typedef hz_bcnt_t (logic [2:0])
- One sub-module, hazard_perf_counter: a single saturating 32-bit counter with inc and nRST. It is instantiated three times, only under HAZARD_PERF_CNT_EN.

## Test plan
- Load-use, LOAD_BUBBLES=1: ex_memrd=1, ex_wsel=8, id_rs=8, ihit=1.
  - Expected: pc_en=0, stage_en=4'b1110, stage_flush=4'b0010 for one cycle, then 4'b1111 enables.
- Register-0 immunity: ex_memrd=1, ex_wsel=0, id_rs=0.
  - Expected: no stall, all enables 1.
- LOAD_BUBBLES=3 stall with a fetch miss:
  - Hazard, then ihit=0 for 2 cycles, then ihit=1.
  - Expected: exactly 3 bubble-advance cycles in total; outputs hold during the ihit=0 cycles.
- Redirect with a simultaneous hazard: redirect=1, luhaz=1, ihit=1.
  - Expected: stage_flush=4'b0011, pc_en=1, state stays HZ_RUN.
- Data hit during a fetch miss: dmem_req=1, dhit=1, ihit=0.
  - Expected: stage_en=4'b1100, stage_flush=4'b0100, pc_en=0.
- Reset mid-stall: LOAD_BUBBLES=4, nRST low during the second bubble.
  - Expected: flush 4'b1111; after release normal HZ_RUN. With the macro defined, all counters read 0.
